// File: rtl/sub_borrow_chain.sv
// -----------------------------------------------------------------------------
// sub_borrow_chain
//
// Sequential multi-precision subtractor. Operands arrive as WIDTH-bit limbs,
// least significant first, over a valid/ready handshake. Each accepted limb
// produces one result limb A - B - borrow. The borrow is chained from one
// accepted limb to the next.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   in_valid   input limb present
//   in_ready   limb accepted this cycle (combinational: !out_valid || out_ready)
//   in_first   limb is the least significant of an operand
//   in_last    limb is the most significant of an operand
//   a, b       minuend / subtrahend limbs
//   bin        external borrow-in, used only when an operand starts
//   out_valid  result limb present
//   out_ready  consumer accepts the result limb
//   diff       result limb
//   out_last   result limb is the most significant
//   bout       borrow out of this limb (final borrow on out_last)
//   zero       all result limbs of the operand so far are zero
//   ovf        signed overflow, only on out_last
//   err        protocol violation seen on this beat
//   count      limb index within the operand, saturating
// -----------------------------------------------------------------------------
module sub_borrow_chain #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             out_last,
    output logic             bout,
    output logic             zero,
    output logic             ovf,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Limb index increment that sticks at the all-ones value.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    // Signed overflow of the whole operand, judged from its most significant limb.
    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] d);
        return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
    endfunction

    logic [0:0]       state_q;
    logic             brw_q;

    logic             vld_p1;
    logic [WIDTH-1:0] diff_p1;
    logic             last_p1;
    logic             bout_p1;
    logic             zero_p1;
    logic             ovf_p1;
    logic             err_p1;
    logic [CNT_W-1:0] cnt_p1;

    logic             accept_p0;
    logic             first_p0;
    logic             brw_use_p0;
    logic [WIDTH:0]   sub_p0;
    logic [WIDTH-1:0] diff_p0;
    logic             bout_p0;
    logic             zero_p0;
    logic             ovf_p0;
    logic             err_p0;
    logic [CNT_W-1:0] cnt_p0;

    // ---- stage p0: combinational limb arithmetic on the accepted input ----
    // One-deep output register with pass-through: a draining result frees the slot.
    assign in_ready  = !vld_p1 || out_ready;
    assign accept_p0 = in_valid && in_ready;

    // A limb arriving with no operand open always starts a new operand.
    assign first_p0   = in_first || (state_q == IDLE);
    assign err_p0     = (in_first && (state_q == BUSY)) || (!in_first && (state_q == IDLE));
    assign brw_use_p0 = first_p0 ? bin : brw_q;

    assign sub_p0  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, brw_use_p0};
    assign diff_p0 = sub_p0[WIDTH-1:0];
    assign bout_p0 = sub_p0[WIDTH];

    // zero_p1/cnt_p1 always hold the previous accepted limb of the operand.
    assign zero_p0 = (diff_p0 == '0) && (first_p0 || zero_p1);
    assign cnt_p0  = first_p0 ? '0 : cnt_sat_inc(cnt_p1);
    assign ovf_p0  = in_last && sub_ovf(a, b, diff_p0);

    // ---- stage p1: output register and chaining state ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            brw_q   <= 1'b0;
            vld_p1  <= 1'b0;
            diff_p1 <= '0;
            last_p1 <= 1'b0;
            bout_p1 <= 1'b0;
            zero_p1 <= 1'b0;
            ovf_p1  <= 1'b0;
            err_p1  <= 1'b0;
            cnt_p1  <= '0;
        end else if (accept_p0) begin
            state_q <= in_last ? IDLE : BUSY;
            brw_q   <= bout_p0;
            vld_p1  <= 1'b1;
            diff_p1 <= diff_p0;
            last_p1 <= in_last;
            bout_p1 <= bout_p0;
            zero_p1 <= zero_p0;
            ovf_p1  <= ovf_p0;
            err_p1  <= err_p0;
            cnt_p1  <= cnt_p0;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign diff      = diff_p1;
    assign out_last  = last_p1;
    assign bout      = bout_p1;
    assign zero      = zero_p1;
    assign ovf       = ovf_p1;
    assign err       = err_p1;
    assign count     = cnt_p1;

endmodule

// File: tb/tb_sub_borrow_chain.sv
// -----------------------------------------------------------------------------
// tb_sub_borrow_chain
//
// Bench for sub_borrow_chain at WIDTH=8, CNT_W=4: a directed vector table,
// hand-written multi-cycle sequences (backpressure, reset mid-operand, count
// saturation) and a randomized phase checked against an operand-level model.
// -----------------------------------------------------------------------------
module tb_sub_borrow_chain;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic         in_last;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         out_last;
    logic         bout;
    logic         zero;
    logic         ovf;
    logic         err;
    logic [C-1:0] count;

    sub_borrow_chain #(.WIDTH(W), .CNT_W(C)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_first (in_first),
        .in_last  (in_last),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .out_last (out_last),
        .bout     (bout),
        .zero     (zero),
        .ovf      (ovf),
        .err      (err),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         f;
        logic         l;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;
        logic [W-1:0] d;
        logic         bo;
        logic         z;
        logic         ov;
        logic         er;
        logic [C-1:0] c;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         z;
        logic         ov;
        logic         er;
        logic [C-1:0] c;
        logic         ol;
    } res_t;

    int checks   = 0;
    int failures = 0;

    vec_t tbl[14];
    res_t exp_q[$];

    // operand-level reference model state
    bit              m_open = 0;
    longint unsigned m_a, m_b;
    int              m_k;
    bit              m_b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic chk_res(input string nm, input res_t e);
        chk({nm, ".valid"}, 32'(out_valid), 32'd1);
        chk({nm, ".diff"},  32'(diff),      32'(e.d));
        chk({nm, ".bout"},  32'(bout),      32'(e.bo));
        chk({nm, ".zero"},  32'(zero),      32'(e.z));
        chk({nm, ".ovf"},   32'(ovf),       32'(e.ov));
        chk({nm, ".err"},   32'(err),       32'(e.er));
        chk({nm, ".count"}, 32'(count),     32'(e.c));
        chk({nm, ".last"},  32'(out_last),  32'(e.ol));
    endtask

    // Treats the operand limbs seen so far as whole numbers A and B and
    // derives the current result limb from A - B - bin over those limbs.
    function automatic res_t model(input logic f, input logic l, input logic [W-1:0] av,
                                   input logic [W-1:0] bv, input logic bi);
        res_t            r;
        longint unsigned mask, total;
        r.er = f ? m_open : !m_open;
        if (f || !m_open) begin
            m_a = 0; m_b = 0; m_k = 0; m_b0 = bi;
        end else begin
            m_k++;
        end
        m_a  = m_a | (longint'(av) << (W * m_k));
        m_b  = m_b | (longint'(bv) << (W * m_k));
        mask = (64'd1 << (W * (m_k + 1))) - 1;
        total = (m_a - m_b - longint'(m_b0)) & mask;
        r.d  = W'(total >> (W * m_k));
        r.bo = (m_a < m_b + longint'(m_b0));
        r.z  = (total == 0);
        r.c  = (m_k > 15) ? C'(15) : C'(m_k);
        r.ov = l && (av[W-1] != bv[W-1]) && (r.d[W-1] != av[W-1]);
        r.ol = l;
        m_open = !l;
        return r;
    endfunction

    task automatic drive(input logic f, input logic l, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic bi);
        in_valid = 1'b1; in_first = f; in_last = l; a = av; b = bv; bin = bi;
    endtask

    task automatic apply_vec(input int i);
        res_t e;
        drive(tbl[i].f, tbl[i].l, tbl[i].a, tbl[i].b, tbl[i].bi);
        @(posedge clk); #1;
        e = '{tbl[i].d, tbl[i].bo, tbl[i].z, tbl[i].ov, tbl[i].er, tbl[i].c, tbl[i].l};
        chk_res($sformatf("vec%0d", i), e);
    endtask

    initial begin
        //         f  l  a      b      bi  d      bo z  ov er c
        tbl[0]  = '{1, 1, 8'h05, 8'h03, 0, 8'h02, 0, 0, 0, 0, 4'd0};
        tbl[1]  = '{1, 0, 8'h00, 8'h01, 0, 8'hFF, 1, 0, 0, 0, 4'd0};
        tbl[2]  = '{0, 0, 8'h00, 8'h00, 0, 8'hFF, 1, 0, 0, 0, 4'd1};
        tbl[3]  = '{0, 1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 0, 0, 4'd2};
        tbl[4]  = '{1, 0, 8'h34, 8'h34, 0, 8'h00, 0, 1, 0, 0, 4'd0};
        tbl[5]  = '{0, 1, 8'h12, 8'h12, 0, 8'h00, 0, 1, 0, 0, 4'd1};
        tbl[6]  = '{1, 1, 8'h80, 8'h01, 0, 8'h7F, 0, 0, 1, 0, 4'd0};
        tbl[7]  = '{1, 0, 8'h10, 8'h20, 0, 8'hF0, 1, 0, 0, 0, 4'd0};
        tbl[8]  = '{1, 0, 8'h05, 8'h01, 1, 8'h03, 0, 0, 0, 1, 4'd0};
        tbl[9]  = '{0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0, 4'd1};
        tbl[10] = '{0, 1, 8'h07, 8'h07, 1, 8'hFF, 1, 0, 0, 1, 4'd0};
        tbl[11] = '{1, 1, 8'h00, 8'h00, 1, 8'hFF, 1, 0, 0, 0, 4'd0};
        tbl[12] = '{1, 1, 8'h00, 8'h00, 0, 8'h00, 0, 1, 0, 0, 4'd0};
        tbl[13] = '{1, 1, 8'h7F, 8'hFF, 0, 8'h80, 1, 0, 1, 0, 4'd0};

        reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk_res_reset();
        reset = 1'b0;

        // directed vectors, back-to-back with out_ready held high
        for (int i = 0; i < 14; i++) apply_vec(i);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain.valid", 32'(out_valid), 32'd0);

        // backpressure: result held for 3 cycles, then one limb per cycle
        drive(1, 0, 8'h10, 8'h01, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(0, 0, 8'h00, 8'h00, 0);
        #1;
        chk("bp.in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_res($sformatf("bp.hold%0d", i), '{8'h0F, 0, 0, 0, 0, 4'd0, 0});
            chk("bp.in_ready_h", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk_res("bp.y", '{8'h00, 0, 0, 0, 0, 4'd1, 0});
        drive(0, 1, 8'h00, 8'h00, 0);
        @(posedge clk); #1;
        chk_res("bp.z", '{8'h00, 0, 0, 0, 0, 4'd2, 1});
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp.nodup", 32'(out_valid), 32'd0);

        // reset mid-operand, then the chain must match a fresh start
        drive(1, 0, 8'h00, 8'h01, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk_res_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 1; i < 4; i++) apply_vec(i);
        in_valid = 1'b0;

        // long operand: count saturates at 15
        for (int i = 0; i < 18; i++) begin
            drive(i == 0, i == 17, 8'h00, 8'h00, 0);
            @(posedge clk); #1;
            chk($sformatf("sat.count%0d", i), 32'(count), (i > 15) ? 32'd15 : 32'(i));
            chk($sformatf("sat.zero%0d", i), 32'(zero), 32'd1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        run_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic chk_res_reset();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.diff",  32'(diff),      32'd0);
        chk("rst.last",  32'(out_last),  32'd0);
        chk("rst.bout",  32'(bout),      32'd0);
        chk("rst.zero",  32'(zero),      32'd0);
        chk("rst.ovf",   32'(ovf),       32'd0);
        chk("rst.err",   32'(err),       32'd0);
        chk("rst.count", 32'(count),     32'd0);
    endtask

    task automatic run_random();
        int     gen_len = 1;
        int     gen_idx = 0;
        bit     pend = 0;
        bit     hold_v = 0;
        logic   gl = 1'b0;
        res_t   hold_r;
        res_t   e;
        m_open = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!pend && ($urandom % 4 != 0)) begin
                if (gen_idx == 0) gen_len = $urandom_range(1, 5);
                gl = (gen_idx == gen_len - 1);
                drive(gen_idx == 0, gl, W'($urandom), W'($urandom), 1'($urandom));
                if ($urandom % 12 == 0) in_first = !in_first;
                pend = 1;
            end
            in_valid  = pend;
            out_ready = ($urandom % 3 != 0);
            @(negedge clk);
            if (hold_v) chk_res("rnd.hold", hold_r);
            hold_v = out_valid && !out_ready;
            hold_r = '{diff, bout, zero, ovf, err, count, out_last};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd.unexpected", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk_res("rnd", e);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_first, in_last, a, b, bin));
                pend = 0;
                gen_idx = gl ? 0 : gen_idx + 1;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        if (out_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk_res("rnd.tail", e);
        end
        @(posedge clk); #1;
        chk("rnd.left", 32'(exp_q.size()), 32'd0);
        chk("rnd.idle", 32'(out_valid), 32'd0);
    endtask

endmodule

// File: doc/sub_borrow_chain.md
# sub_borrow_chain

Sequential multi-precision subtractor and the borrow-side counterpart of the carry adder in the integer datapath. It accepts operands as a stream of WIDTH-bit limbs, least significant first, over a valid/ready handshake. Each result limb is A − B − borrow, and the borrow is chained across limbs from one cycle to the next. It emits result limbs with the final borrow, a whole-result zero flag, a signed-overflow flag, and a protocol-error flag. It feeds the decode system's wide-arithmetic path and the unit-test benches that previously drove only the adder.

## Interface
- WIDTH, 32, limb width in bits (≥2)
- CNT_W, 4, width of the limb counter

- clk  in  1  clock, rising-edge active
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  input limb present
- in_ready  out  1  block accepts the limb this cycle
- in_first  in  1  limb is the least significant of an operand
- in_last  in  1  limb is the most significant of an operand
- a  in  WIDTH  minuend limb
- b  in  WIDTH  subtrahend limb
- bin  in  1  external borrow-in, used only on a first limb
- out_valid  out  1  result limb present
- out_ready  in  1  consumer accepts the result limb
- diff  out  WIDTH  result limb
- out_last  out  1  result limb is the most significant
- bout  out  1  borrow out of this limb; final borrow when out_last=1
- zero  out  1  all limbs of the operand so far are zero; final when out_last=1
- ovf  out  1  signed overflow; meaningful only when out_last=1, else 0
- err  out  1  protocol violation detected on this beat
- count  out  CNT_W  index of this limb within the operand, saturating at 2^CNT_W−1

## Operation
- States: IDLE (no operand open) and BUSY (operand open, last limb not yet accepted).
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. The output register is one entry deep, with a pass-through when it is being drained.
- Borrow used by an accepted limb:
  - bin if in_first=1, or if the state is IDLE.
  - Otherwise the internal borrow register.
- Arithmetic:
  - {bout, diff} = {1'b0,a} − {1'b0,b} − borrow_used, taken modulo 2^(WIDTH+1).
  - bout = 1 exactly when a < b + borrow_used.
- Internal borrow register: loaded with bout on every accept.
- zero:
  - On a first limb, zero = (diff == 0).
  - Otherwise, zero = previous zero && (diff == 0).
- ovf on a last limb = (a[WIDTH−1] ≠ b[WIDTH−1]) && (diff[WIDTH−1] ≠ a[WIDTH−1]). ovf is 0 on all other limbs.
- count:
  - 0 on a first limb.
  - Otherwise previous count + 1, saturating at 2^CNT_W−1.
- Transitions:
  - IDLE + accept with in_last=0 → BUSY.
  - IDLE + accept with in_last=1 → IDLE (single-limb operand).
  - BUSY + accept with in_last=1 → IDLE.
- Protocol errors (err=1 on that result beat; processing continues):
  - in_first=1 while BUSY: the open operand is abandoned and a new operand starts, with borrow = bin and count = 0.
  - in_first=0 while IDLE: the limb is treated as a first limb.
- out_last is a copy of in_last for the accepted limb.

## Timing
- Latency: a limb accepted at edge N appears on diff/flags with out_valid=1 after edge N.
- Result hold: out_valid and all result outputs stay stable while out_valid && !out_ready.
- Throughput: one limb per cycle when out_ready is held at 1.
- Simultaneous drain and accept: the output register is overwritten with the new limb at the same edge; no bubble.
- Reset values: state = IDLE, borrow register = 0, out_valid = 0, diff = 0, out_last = 0, bout = 0, zero = 0, ovf = 0, err = 0, count = 0.
- in_ready is combinational from out_valid and out_ready, so it is 1 during reset.
- Reset mid-operand: the open operand and any pending result are discarded with no output. The next limb is treated as a first limb.

## Test plan
- Single limb, WIDTH=8: a=0x05, b=0x03, bin=0, first=last=1 → diff=0x02, bout=0, zero=0, ovf=0, out_last=1, count=0, one cycle after accept.
- Three-limb borrow chain, WIDTH=8, limbs LSB first: a=(00,00,01), b=(01,00,00), bin=0 → diff=(FF,FF,00), bout=(1,1,0), zero=0, count=0,1,2.
- Equal operands and signed overflow, WIDTH=8:
  - a=(34,12), b=(34,12) → diff=(00,00), zero=1 on the last limb.
  - Single limb a=0x80, b=0x01 → diff=0x7F, ovf=1, bout=0.
- Backpressure: out_ready=0 for 3 cycles with a valid result present → in_ready=0, and diff/flags held constant. Releasing out_ready gives one limb per cycle with no loss or duplication.
- Protocol error: in_first=1 arrives on limb 2 of an open operand → err=1 on that beat, count=0, and the borrow comes from bin. Separately, a limb with in_first=0 while IDLE → err=1 and the limb is treated as a first limb.
- Reset mid-operand: assert reset after limb 1 of a 3-limb operand → out_valid=0 immediately. The next operand gives results identical to those from a fresh power-up.
